// File: rtl/periph_timer.sv
// periph_timer: memory-mapped reloadable interval timer with a read-only
// SYSTICK window onto the free-running system cycle counter.
//   BASE+0x00  TH       reload value
//   BASE+0x04  TL       counter
//   BASE+0x08  TCON     {irq status, irq enable, enable}
//   BASE+0x14  SYSTICK  clk_num pass-through (writes ignored)
module periph_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    input  logic [31:0] clk_num,
    output logic [31:0] ReadData,
    output logic        irq
);

    localparam logic [31:0] TH_ADDR      = BASE_ADDR;
    localparam logic [31:0] TL_ADDR      = BASE_ADDR + 32'd4;
    localparam logic [31:0] TCON_ADDR    = BASE_ADDR + 32'd8;
    localparam logic [31:0] SYSTICK_ADDR = BASE_ADDR + 32'd20;
    localparam logic [31:0] TL_MAX       = 32'hFFFF_FFFF;

    logic [31:0] th_r;
    logic [31:0] tl_r;
    logic [2:0]  tcon_r;
    logic        irq_r;

    logic [31:0] th_next_s;
    logic [31:0] tl_next_s;
    logic [2:0]  tcon_next_s;
    logic        wr_th_s;
    logic        wr_tl_s;
    logic        wr_tcon_s;
    logic        ovf_s;
    logic        status_set_s;

    // Exact word-address write decode; SYSTICK and unmapped addresses decode to nothing.
    always_comb begin
        wr_th_s   = MemWrite & (Address == TH_ADDR);
        wr_tl_s   = MemWrite & (Address == TL_ADDR);
        wr_tcon_s = MemWrite & (Address == TCON_ADDR);
    end

    // Next-state: count/reload from pre-edge enable, TL write wins over counting,
    // an overflow status set wins over a software clear in the same cycle.
    always_comb begin
        th_next_s    = th_r;
        tl_next_s    = tl_r;
        tcon_next_s  = tcon_r;
        ovf_s        = 1'b0;
        status_set_s = 1'b0;

        if (wr_tl_s) begin
            tl_next_s = WriteData;
        end else if (tcon_r[0]) begin
            if (tl_r == TL_MAX) begin
                ovf_s     = 1'b1;
                tl_next_s = th_r;
            end else begin
                tl_next_s = tl_r + 32'd1;
            end
        end else begin
            tl_next_s = tl_r;
        end

        status_set_s = ovf_s & tcon_r[1];

        if (wr_th_s) begin
            th_next_s = WriteData;
        end else begin
            th_next_s = th_r;
        end

        if (wr_tcon_s) begin
            tcon_next_s = {WriteData[2] | status_set_s, WriteData[1:0]};
        end else begin
            tcon_next_s = {tcon_r[2] | status_set_s, tcon_r[1:0]};
        end
    end

    // Timer state registers; irq is registered from the same next-state so it
    // tracks TCON[1] & TCON[2] exactly and has no path from the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_r   <= 32'h0;
            tl_r   <= 32'h0;
            tcon_r <= 3'b000;
            irq_r  <= 1'b0;
        end else begin
            th_r   <= th_next_s;
            tl_r   <= tl_next_s;
            tcon_r <= tcon_next_s;
            irq_r  <= tcon_next_s[1] & tcon_next_s[2];
        end
    end

    // Combinational read mux so a MEM-stage load completes in the same cycle.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            case (Address)
                TH_ADDR:      ReadData = th_r;
                TL_ADDR:      ReadData = tl_r;
                TCON_ADDR:    ReadData = {29'd0, tcon_r};
                SYSTICK_ADDR: ReadData = clk_num;
                default:      ReadData = 32'h0;
            endcase
        end else begin
            ReadData = 32'h0;
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_periph_timer.sv
// Self-checking bench for periph_timer: directed scenarios followed by
// randomized bus traffic checked against a register-level reference model.
module tb_periph_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;
    localparam logic [31:0] A_ST = BASE + 32'd20;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] clk_num;
    logic [31:0] ReadData;
    logic        irq;

    int n_cmp;
    int n_fail;

    // reference model state
    logic [31:0] m_th;
    logic [31:0] m_tl;
    logic [2:0]  m_tcon;

    periph_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .Address(Address), .MemRead(MemRead),
        .MemWrite(MemWrite), .WriteData(WriteData), .clk_num(clk_num),
        .ReadData(ReadData), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == A_TH) return m_th;
        if (a == A_TL) return m_tl;
        if (a == A_TC) return {29'd0, m_tcon};
        if (a == A_ST) return clk_num;
        return 32'h0;
    endfunction

    function automatic logic m_irq();
        return m_tcon[1] & m_tcon[2];
    endfunction

    // One clock edge of the timer as described register by register.
    task automatic m_edge(input logic [31:0] a, input logic we, input logic [31:0] wd);
        logic        tl_written;
        logic        wrapped;
        logic        raise;
        logic [31:0] tl_new;
        logic [2:0]  tc_new;
        tl_written = we && (a == A_TL);
        wrapped    = m_tcon[0] && !tl_written && (m_tl == 32'hFFFF_FFFF);
        raise      = wrapped && m_tcon[1];
        if (tl_written)      tl_new = wd;
        else if (wrapped)    tl_new = m_th;
        else if (m_tcon[0])  tl_new = m_tl + 32'd1;
        else                 tl_new = m_tl;
        if (we && a == A_TC) tc_new = {wd[2] | raise, wd[1:0]};
        else                 tc_new = {m_tcon[2] | raise, m_tcon[1:0]};
        if (we && a == A_TH) m_th = wd;
        m_tl   = tl_new;
        m_tcon = tc_new;
    endtask

    task automatic m_reset();
        m_th = 32'h0; m_tl = 32'h0; m_tcon = 3'b000;
    endtask

    // advance one edge with the currently driven bus, then check irq
    task automatic tick();
        @(posedge clk);
        if (reset) m_edge(Address, MemWrite, WriteData);
        #1;
        chk("irq", {31'd0, irq}, {31'd0, m_irq()});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        tick();
        MemWrite = 1'b0; WriteData = 32'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a; MemRead = 1'b1;
        #1;
        chk(tag, ReadData, exp);
        chk({tag, "_model"}, ReadData, m_read(a));
        MemRead = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        Address = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
        WriteData = 32'h0; clk_num = 32'h0;
        m_reset();

        // ---- reset then idle
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd("rst_th", A_TH, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd("idle_th", A_TH, 32'h0);
        rd("idle_tl", A_TL, 32'h0);
        rd("idle_tcon", A_TC, 32'h0);
        chk("idle_irq", {31'd0, irq}, 32'd0);
        clk_num = 32'h1234;
        rd("systick", A_ST, 32'h1234);
        Address = A_TL; MemRead = 1'b0; #1;
        chk("noread_zero", ReadData, 32'h0);

        // ---- basic count
        bus_write(A_TL, 32'd5);
        bus_write(A_TC, 32'd1);
        rd("cnt5", A_TL, 32'd5);
        tick(); rd("cnt6", A_TL, 32'd6);
        tick(); rd("cnt7", A_TL, 32'd7);
        tick(); rd("cnt8", A_TL, 32'd8);
        bus_write(A_TC, 32'd0);
        rd("stop9", A_TL, 32'd9);
        tick(); tick();
        rd("frozen9", A_TL, 32'd9);
        bus_write(A_ST, 32'hDEAD_BEEF);
        rd("systick_ro", A_ST, 32'h1234);

        // ---- overflow, reload, irq
        bus_write(A_TH, 32'hFFFF_FFF0);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TC, 32'd3);
        tick(); rd("ovf_ff", A_TL, 32'hFFFF_FFFF);
        tick(); rd("ovf_reload", A_TL, 32'hFFFF_FFF0);
        rd("ovf_tcon", A_TC, 32'd7);
        chk("ovf_irq", {31'd0, irq}, 32'd1);
        rd("tcon_reread", A_TC, 32'd7);
        bus_write(A_TC, 32'd3);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        rd("clr_tcon", A_TC, 32'd3);
        bus_write(A_TC, 32'd0);

        // ---- overflow with irq disabled
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TC, 32'd1);
        tick(); tick();
        rd("noirq_reload", A_TL, 32'hFFFF_FFF0);
        rd("noirq_tcon", A_TC, 32'd1);
        chk("noirq_irq", {31'd0, irq}, 32'd0);
        bus_write(A_TC, 32'd0);

        // ---- collisions
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TC, 32'd3);
        tick();
        rd("col_pre", A_TL, 32'hFFFF_FFFF);
        bus_write(A_TL, 32'h10);
        rd("col_tl", A_TL, 32'h10);
        rd("col_tl_tcon", A_TC, 32'd3);
        bus_write(A_TL, 32'hFFFF_FFFF);
        Address = A_TC; MemRead = 1'b1; #1;
        chk("rw_same_pre", ReadData, 32'd3);
        MemRead = 1'b0;
        bus_write(A_TC, 32'd3);
        rd("col_tcon", A_TC, 32'd7);
        chk("col_irq", {31'd0, irq}, 32'd1);

        // ---- async reset mid-operation
        tick();
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("arst_irq", {31'd0, irq}, 32'd0);
        rd("arst_tl", A_TL, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick(); tick();
        rd("arst_hold", A_TL, 32'h0);
        bus_write(A_TC, 32'd1);
        tick();
        rd("arst_resume", A_TL, 32'd1);

        // ---- randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [31:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0: a = A_TH;
                1: a = A_TL;
                2, 3: a = A_TC;
                4: a = A_ST;
                default: a = BASE + 32'($urandom_range(0, 31));
            endcase
            d = $urandom;
            if (a == A_TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if (a == A_TH && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
            if (a == A_TC && $urandom_range(0, 2) != 0) d = 32'($urandom_range(0, 3)) | 32'd1;
            clk_num = $urandom;
            Address = a;
            WriteData = d;
            MemWrite = (op < 4);
            MemRead = (op >= 2);
            #1;
            chk("rnd_read", ReadData, MemRead ? m_read(a) : 32'h0);
            tick();
            MemWrite = 1'b0;
            if (op == 9) begin
                rd("rnd_tl", A_TL, m_tl);
                rd("rnd_tcon", A_TC, {29'd0, m_tcon});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_timer.md
Name: periph_timer

Overview:
- Memory-mapped timer/counter peripheral on the CPU data bus.
- Consumes the free-running 32-bit cycle count from the system clock counter and exposes it read-only as SYSTICK.
- Also provides a reloadable interval timer (TH/TL/TCON) that raises an interrupt request to the pipeline's exception logic.
- Reads are combinational, so a load in the MEM stage completes in the same cycle.

Parameters:
- BASE_ADDR, 32'h40000000, byte address of TH. TL = BASE+4, TCON = BASE+8, SYSTICK = BASE+20 (0x14).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- Address  input  32  byte address from MEM stage
- MemRead  input  1  load strobe
- MemWrite  input  1  store strobe
- WriteData  input  32  store data
- clk_num  input  32  free-running cycle count from the system clock counter
- ReadData  output  32  read data, combinational
- irq  output  1  interrupt request to the exception/PC logic

Behaviour:
- Reset (reset==0, asynchronous):
  - TH=0, TL=0, TCON=3'b000.
  - irq=0.
  - ReadData follows the decode rules below (0 unless a read hits).
- Registers:
  - TH[31:0]: reload value.
  - TL[31:0]: counter.
  - TCON[2:0]: bit0 = enable, bit1 = irq enable, bit2 = irq status.
- Counting, each clk edge with TCON[0]==1 and no write to TL:
  - If TL != 32'hFFFFFFFF: TL <= TL+1.
  - If TL == 32'hFFFFFFFF (overflow): TL <= TH, and TCON[2] <= 1 if TCON[1]==1.
  - Overflow reload happens on the same edge as the wrap; there is no cycle at value 0 unless TH==0.
- TCON[0]==0: TL holds. No overflow and no status set.
- Writes take effect on the edge when MemWrite==1 and Address matches exactly (word addresses only):
  - BASE: TH <= WriteData.
  - BASE+4: TL <= WriteData. A TL write overrides increment/reload that cycle, and no overflow event occurs that cycle.
  - BASE+8: TCON[1:0] <= WriteData[1:0]; TCON[2] <= WriteData[2] | overflow_set_this_cycle. An overflow set beats a software clear, so no interrupt is lost.
  - BASE+20 (SYSTICK): writes ignored.
  - Any other address: no effect.
- Enable and irq-enable sampling:
  - Enable used for counting is the pre-edge TCON[0]. A write enabling the timer takes effect from the next edge.
  - irq-enable used for the overflow set is the pre-edge TCON[1].
- irq = TCON[1] & TCON[2], registered-state derived, no combinational path from the bus inputs.
- Read mux (combinational), when MemRead==1:
  - BASE -> TH.
  - BASE+4 -> TL.
  - BASE+8 -> {29'b0, TCON}.
  - BASE+20 -> clk_num (passed through unregistered).
  - Otherwise, or when MemRead==0 -> 32'h0.
- Reads have no side effects. Reading TCON does not clear status.
- Simultaneous MemRead and MemWrite to the same register: ReadData returns the pre-edge value.
- Reset mid-count: TL and TCON clear immediately. irq drops in the same cycle reset asserts (asynchronous).

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release. Required: ReadData=0 for reads of TH/TL/TCON and irq=0. Read BASE+20 with clk_num=32'h1234 -> ReadData=32'h1234.
- Basic count:
  - Write TL=5, then TCON=3'b001.
  - Required: TL reads 5 on the edge after the TCON write, then 6, 7, 8 on successive cycles.
  - Write TCON=0 -> TL frozen at its current value.
- Overflow/reload/irq:
  - TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, TCON=3'b011.
  - Required: TL reads FFFFFFFF, then FFFFFFF0 on the next edge.
  - TCON then reads 3'b111 and irq=1.
  - Write TCON=3'b011 -> irq=0 next cycle.
- Overflow with irq disabled: same as above but TCON=3'b001 -> reload occurs, TCON stays 3'b001, irq never asserts.
- Collisions:
  - Write TL=32'h10 on the exact overflow edge -> TL=32'h10, TCON[2] unchanged.
  - Write TCON=3'b011 (clear) on an overflow edge with TCON[1]=1 -> TCON reads 3'b111, irq stays 1.
- Async reset mid-operation: counting with irq=1, drop reset between edges -> irq and TL are 0 before the next clk edge. After release, counting does not resume until TCON is rewritten.
